// File: rtl/param_choice_pht.sv
// Tournament chooser PHT: per-index saturating counters select the bimodal (0) or global (1)
// predictor, trained in program order from a deferred-update FIFO of fetch-time lookups.
module param_choice_pht #(
    parameter int IDX_W  = 8,
    parameter int CTR_W  = 2,
    parameter int FIFO_D = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    stallreq,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic                    pred_method,
    input  logic                    alloc_valid,
    input  logic [IDX_W-1:0]        alloc_idx,
    input  logic                    alloc_pred_b,
    input  logic                    alloc_pred_g,
    output logic                    alloc_ready,
    input  logic                    res_valid,
    input  logic                    res_taken,
    input  logic                    flush,
    output logic [$clog2(FIFO_D):0] fifo_count,
    output logic                    err_ovf,
    output logic                    err_udf
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int PTR_W   = $clog2(FIFO_D);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_D);

    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [IDX_W-1:0]   fifo_idx_q [FIFO_D];
    logic [FIFO_D-1:0]  fifo_b_q;
    logic [FIFO_D-1:0]  fifo_g_q;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;

    logic               pop_s;
    logic               alloc_ready_s;
    logic               alloc_fire_s;
    logic               init_s;
    logic               train_s;
    logic [IDX_W-1:0]   head_idx_s;
    logic               head_b_s;
    logic               head_g_s;
    logic [CTR_W-1:0]   head_ctr_s;
    logic [CTR_W-1:0]   train_val_s;

    // Handshake decode, head training value and next pointer/occupancy/error state.
    always_comb begin
        pop_s         = res_valid & ~stallreq & (count_q != {CNT_W{1'b0}});
        alloc_ready_s = (count_q != CNT_FULL) | pop_s;
        alloc_fire_s  = alloc_valid & ~stallreq & ~flush & alloc_ready_s;
        init_s        = alloc_fire_s & ~valid_q[alloc_idx];

        head_idx_s = fifo_idx_q[rd_ptr_q];
        head_b_s   = fifo_b_q[rd_ptr_q];
        head_g_s   = fifo_g_q[rd_ptr_q];
        head_ctr_s = ctr_q[head_idx_s];

        // A same-cycle first allocation of the head's index re-initialises it; training yields.
        train_s = pop_s & (head_b_s ^ head_g_s) & ~(init_s & (alloc_idx == head_idx_s));
        if (head_g_s == res_taken) begin
            train_val_s = (head_ctr_s == CTR_MAX) ? CTR_MAX : head_ctr_s + CTR_ONE;
        end else begin
            train_val_s = (head_ctr_s == CTR_ZERO) ? CTR_ZERO : head_ctr_s - CTR_ONE;
        end

        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            wr_ptr_d = alloc_fire_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            case ({alloc_fire_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        err_ovf_d = alloc_valid & ~stallreq & ~flush & ~alloc_ready_s;
        err_udf_d = res_valid & ~stallreq & (count_q == {CNT_W{1'b0}});
    end

    // Control state with synchronous reset: pointers, occupancy, error pulses, valid bits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q  <= {PTR_W{1'b0}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
            valid_q   <= {ENTRIES{1'b0}};
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
            if (init_s) begin
                valid_q[alloc_idx] <= 1'b1;
            end
        end
    end

    // Storage without reset: counters deliberately survive reset, FIFO payload is gated by occupancy.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (alloc_fire_s) begin
                fifo_idx_q[wr_ptr_q] <= alloc_idx;
                fifo_b_q[wr_ptr_q]   <= alloc_pred_b;
                fifo_g_q[wr_ptr_q]   <= alloc_pred_g;
            end
            if (train_s) begin
                ctr_q[head_idx_s] <= train_val_s;
            end
            if (init_s) begin
                ctr_q[alloc_idx] <= CTR_INIT;
            end
        end
    end

    assign pred_method = resetn & valid_q[rd_idx] & ctr_q[rd_idx][CTR_W-1];
    assign alloc_ready = alloc_ready_s;
    assign fifo_count  = count_q;
    assign err_ovf     = err_ovf_q;
    assign err_udf     = err_udf_q;

endmodule
